addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; matches the 16-bit add/subtract unit.
REQ-002 Parameter: TIMEOUT, 15, max WAIT cycles for add_ready before error completion; 1..255.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req0_valid, req1_valid  in  1 each  requester N has an operation pending.
REQ-006 req0_a, req0_b, req1_a, req1_b  in  WIDTH each  operands of requester N.
REQ-007 req0_sub, req1_sub  in  1 each  1 = A-B, 0 = A+B.
REQ-008 req0_ack, req1_ack  out  1 each  one-cycle pulse: request N accepted; operands latched.
REQ-009 rsp_valid  out  1  response available; held until consumed.
REQ-010 rsp_ready  in  1  consumer accepts response.
REQ-011 rsp_id  out  1  requester that owns the response.
REQ-012 rsp_result  out  WIDTH  sum/difference.
REQ-013 rsp_cout  out  1  adder carry-out (no-borrow flag for subtract).
REQ-014 rsp_err  out  1  1 = adder timed out; result forced 0.
REQ-015 add_en, add_cin  out  1 each  adder enable; carry-in = latched sub.
REQ-016 add_a, add_b  out  WIDTH each  latched operands, B unmodified (adder inverts B when cin=1).
REQ-017 add_result, add_cout, add_ready  in  WIDTH, 1, 1  adder outputs.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; exactly one active.
REQ-019 IDLE: if any reqN_valid, grant, pulse reqN_ack, latch a/b/sub/id, go ISSUE; else stay.
REQ-020 Arbitration round-robin: both valid -> grant requester not granted last; single valid -> grant it; pointer updates only on grant.
REQ-021 After reset, pointer favours req0 on first simultaneous request.
REQ-022 At most one ack per cycle; no ack outside IDLE.
REQ-023 ISSUE: add_en=1 one cycle, go WAIT; add_ready ignored in ISSUE (stale from prior op).
REQ-024 WAIT: add_en=1; add_a/add_b/add_cin stable; sample add_ready each cycle.
REQ-025 WAIT with add_ready=1: capture add_result, add_cout, err=0, go RESP.
REQ-026 WAIT counter starts 0, +1 per cycle without ready; reaching TIMEOUT -> result=0, cout=0, err=1, go RESP.
REQ-027 add_ready and timeout same cycle -> add_ready wins, err=0.
REQ-028 RESP: add_en=0; rsp_valid=1, rsp_* stable until rsp_valid&&rsp_ready, then IDLE.
REQ-029 No new request accepted in RESP same cycle as consumption; earliest next ack is cycle after return to IDLE.
REQ-030 Latency: ack cycle T, add_en high from T+1, rsp_valid cycle after add_ready sampled high in WAIT; minimum ack-to-rsp_valid = 3 cycles.
REQ-031 Requester valid dropping after ack has no effect; operands are latched copies.
REQ-032 add_en low in IDLE and RESP; add_a/add_b/add_cin hold last latched values.

Reset
REQ-033 rst_n low: state IDLE immediately, all acks 0, rsp_valid 0, add_en 0, rsp_result/add_a/add_b 0, rsp_id/rsp_cout/rsp_err/add_cin 0, counter 0, pointer favours req0.
REQ-034 Reset mid-ISSUE/WAIT/RESP aborts operation with no response; first ack possible in first clock edge after rst_n rises.

Verification
REQ-035 req0 a=0x0005 b=0x0003 sub=0, adder ready 2 cycles after add_en -> rsp_id=0 result=0x0008 cout=0 err=0.
REQ-036 req1 a=0x0005 b=0x0003 sub=1 -> add_cin=1, rsp_id=1 result=0x0002 cout=1.
REQ-037 Both valid right after reset, ops 0xFFFF+0x0001 and 0x0010-0x0020 -> req0 first (0x0000 cout=1), then req1 (0xFFF0 cout=0); single ack per grant.
REQ-038 add_ready never asserted, TIMEOUT=15 -> rsp_valid 15 WAIT cycles after entry, err=1 result=0x0000.
REQ-039 rsp_ready low 10 cycles with rsp_valid high -> rsp_* stable, no ack, add_en 0; ready high -> IDLE next cycle.
REQ-040 rst_n low during WAIT -> add_en, rsp_valid 0 immediately; no response after release; next request completes normally.

Source files
------------

// File: rtl/addsub_arbiter_if.sv
// rtl/addsub_arbiter_if.sv - request, response and adder signal bundle for addsub_arbiter
interface addsub_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req1_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req0_sub;
    logic             req1_sub;
    logic             req0_ack;
    logic             req1_ack;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_err;

    logic             add_en;
    logic             add_cin;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_result;
    logic             add_cout;
    logic             add_ready;

    modport master (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sub, req1_sub,
        output req0_ack, req1_ack,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_err,
        input  rsp_ready,
        output add_en, add_cin, add_a, add_b,
        input  add_result, add_cout, add_ready
    );

    modport slave (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sub, req1_sub,
        input  req0_ack, req1_ack,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_err,
        output rsp_ready,
        input  add_en, add_cin, add_a, add_b,
        output add_result, add_cout, add_ready
    );
endinterface

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester round-robin front end for a shared add/subtract unit
module addsub_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    addsub_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             grant_any;
    logic             grant_id;
    logic             ack0;
    logic             ack1;
    logic             add_en;

    // Acks are combinational from valid, so they are gated by reset to stay quiet while it is held.
    always_comb begin
        grant_any = rst_n && (bus.req0_valid || bus.req1_valid);
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = bus.req1_valid;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ack0    = 1'b0;
        ack1    = 1'b0;
        add_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    ack0    = ~grant_id;
                    ack1    = grant_id;
                    last_d  = grant_id;
                    id_d    = grant_id;
                    a_d     = grant_id ? bus.req1_a   : bus.req0_a;
                    b_d     = grant_id ? bus.req1_b   : bus.req0_b;
                    sub_d   = grant_id ? bus.req1_sub : bus.req0_sub;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // add_ready may still reflect the previous operation here, so it is not looked at.
                add_en  = 1'b1;
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                add_en = 1'b1;
                if (bus.add_ready) begin
                    res_d   = bus.add_result;
                    cout_d  = bus.add_cout;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // last_q resets to 1 so the first simultaneous request goes to req0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req0_ack   = ack0;
    assign bus.req1_ack   = ack1;
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_cout   = cout_q;
    assign bus.rsp_err    = err_q;
    assign bus.add_en     = add_en;
    assign bus.add_cin    = sub_q;
    assign bus.add_a      = a_q;
    assign bus.add_b      = b_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - randomized self-checking bench for addsub_arbiter
module tb_addsub_arbiter;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    addsub_arbiter_if #(.WIDTH(WIDTH)) bus ();

    addsub_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          ready_delay = -1;
    int          en_cycles = 0;
    bit          rr_last = 1'b1;
    logic [16:0] adder_sum;

    // Adder model: raises add_ready in the (ready_delay+1)-th cycle of add_en, garbage otherwise.
    always @(negedge clk) begin
        if (bus.add_en) en_cycles++;
        else en_cycles = 0;
        if (bus.add_en && ready_delay > 0 && en_cycles == ready_delay + 1) begin
            adder_sum = {1'b0, bus.add_a} + {1'b0, (bus.add_cin ? ~bus.add_b : bus.add_b)} + {16'd0, bus.add_cin};
            bus.add_ready  = 1'b1;
            bus.add_result = adder_sum[15:0];
            bus.add_cout   = adder_sum[16];
        end else begin
            bus.add_ready  = 1'b0;
            bus.add_result = 16'($urandom);
            bus.add_cout   = 1'($urandom);
        end
    end

    function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b, input bit sub);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (sub) return {(ai >= bi) ? 1'b1 : 1'b0, 16'(ai - bi)};
        return {(ai + bi > 65535) ? 1'b1 : 1'b0, 16'(ai + bi)};
    endfunction

    function automatic bit exp_grant(input bit v0, input bit v1);
        if (v0 && v1) return ~rr_last;
        return v1;
    endfunction

    function automatic int exp_lat(input int dly);
        if (dly >= 1 && dly <= TIMEOUT) return dly + 2;
        return TIMEOUT + 2;
    endfunction

    function automatic logic [18:0] exp_rsp(input bit g, input logic [15:0] a, input logic [15:0] b,
                                            input bit sub, input int dly);
        if (dly >= 1 && dly <= TIMEOUT) return {g, 1'b0, ref_op(a, b, sub)};
        return {g, 1'b1, 1'b0, 16'h0000};
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        rr_last = 1'b1;
    endtask

    task automatic txn(input bit v0, input bit v1, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1, input bit s0, input bit s1,
                       input int dly, input int stall,
                       output logic [1:0] acks, output int lat, output logic [18:0] rsp,
                       output logic [32:0] addin, output bit hold_ok);
        int n;
        ready_delay = dly;
        hold_ok = 1'b1;
        lat     = -1;
        rsp     = 'x;
        addin   = 'x;
        @(negedge clk);
        bus.req0_valid = v0; bus.req1_valid = v1;
        bus.req0_a = a0; bus.req0_b = b0; bus.req0_sub = s0;
        bus.req1_a = a1; bus.req1_b = b1; bus.req1_sub = s1;
        #1;
        acks = {bus.req1_ack, bus.req0_ack};
        n = 0;
        while (acks == 2'b00 && n < 30) begin
            @(negedge clk); #1;
            acks = {bus.req1_ack, bus.req0_ack};
            n++;
        end
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom); bus.req0_sub = 1'($urandom);
        bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom); bus.req1_sub = 1'($urandom);
        if (acks == 2'b00) return;
        addin = {bus.add_cin, bus.add_a, bus.add_b};
        n = 1;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) return;
        lat = n;
        rsp = {bus.rsp_id, bus.rsp_err, bus.rsp_cout, bus.rsp_result};
        if (stall > 0) begin
            bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            #1;
            if (bus.req0_ack || bus.req1_ack) hold_ok = 1'b0;
            @(negedge clk); #1;
            if (rsp !== {bus.rsp_id, bus.rsp_err, bus.rsp_cout, bus.rsp_result} ||
                bus.add_en !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.req0_ack || bus.req1_ack)
                hold_ok = 1'b0;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.req0_a = 16'h1234; bus.req0_b = 16'h5678; bus.req0_sub = 1'b1;
        bus.req1_a = 16'h9abc; bus.req1_b = 16'hdef0; bus.req1_sub = 1'b0;
        bus.rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if ({bus.req1_ack, bus.req0_ack} !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b expected 00", {bus.req1_ack, bus.req0_ack}); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        total++; if (bus.add_en !== 1'b0) begin bad++; $display("FAIL reset_add_en: got %b expected 0", bus.add_en); end
        total++; if ({bus.add_cin, bus.add_a, bus.add_b} !== 33'd0) begin bad++; $display("FAIL reset_add_ops: got %h expected 0", {bus.add_cin, bus.add_a, bus.add_b}); end
        total++; if ({bus.rsp_id, bus.rsp_err, bus.rsp_cout, bus.rsp_result} !== 19'd0) begin bad++; $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_id, bus.rsp_err, bus.rsp_cout, bus.rsp_result}); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_last = 1'b1;
    endtask

    task automatic test_single;
        logic [1:0] acks; int lat; logic [18:0] rsp; logic [32:0] addin; bit hold;
        txn(1'b1, 1'b0, 16'h0005, 16'h0003, 16'h7777, 16'h1111, 1'b0, 1'b1, 2, 0, acks, lat, rsp, addin, hold);
        total++; if (acks !== 2'b01) begin bad++; $display("FAIL add0_ack: got %b expected 01", acks); end
        total++; if (rsp !== {1'b0, 1'b0, 1'b0, 16'h0008}) begin bad++; $display("FAIL add0_rsp: got %h expected %h", rsp, {3'b000, 16'h0008}); end
        total++; if (lat !== 4) begin bad++; $display("FAIL add0_lat: got %0d expected 4", lat); end
        total++; if (addin !== {1'b0, 16'h0005, 16'h0003}) begin bad++; $display("FAIL add0_addin: got %h expected %h", addin, {1'b0, 16'h0005, 16'h0003}); end
        rr_last = 1'b0;
        txn(1'b0, 1'b1, 16'h7777, 16'h1111, 16'h0005, 16'h0003, 1'b0, 1'b1, 1, 0, acks, lat, rsp, addin, hold);
        total++; if (acks !== 2'b10) begin bad++; $display("FAIL sub1_ack: got %b expected 10", acks); end
        total++; if (rsp !== {1'b1, 1'b0, 1'b1, 16'h0002}) begin bad++; $display("FAIL sub1_rsp: got %h expected %h", rsp, {3'b101, 16'h0002}); end
        total++; if (lat !== 3) begin bad++; $display("FAIL sub1_min_lat: got %0d expected 3", lat); end
        total++; if (addin !== {1'b1, 16'h0005, 16'h0003}) begin bad++; $display("FAIL sub1_addin: got %h expected %h", addin, {1'b1, 16'h0005, 16'h0003}); end
        rr_last = 1'b1;
    endtask

    task automatic test_simultaneous;
        logic [1:0] acks; int lat; logic [18:0] rsp, er; logic [32:0] addin; bit hold, g;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            g  = exp_grant(1'b1, 1'b1);
            er = exp_rsp(g, g ? 16'h0010 : 16'hFFFF, g ? 16'h0020 : 16'h0001, g, 3);
            txn(1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0010, 16'h0020, 1'b0, 1'b1, 3, 0, acks, lat, rsp, addin, hold);
            total++; if (acks !== (g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_ack%0d: got %b expected %b", k, acks, g ? 2'b10 : 2'b01); end
            total++; if (rsp !== er) begin bad++; $display("FAIL rr_rsp%0d: got %h expected %h", k, rsp, er); end
            rr_last = g;
        end
    endtask

    task automatic test_timeout;
        logic [1:0] acks; int lat; logic [18:0] rsp, er; logic [32:0] addin; bit hold;
        logic [15:0] a, b; bit s;
        int dlys[4] = '{-1, 15, 16, 5};
        foreach (dlys[i]) begin
            a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
            er = exp_rsp(1'b0, a, b, s, dlys[i]);
            txn(1'b1, 1'b0, a, b, 16'h0, 16'h0, s, 1'b0, dlys[i], 0, acks, lat, rsp, addin, hold);
            total++; if (rsp !== er) begin bad++; $display("FAIL timeout_rsp dly=%0d: got %h expected %h", dlys[i], rsp, er); end
            total++; if (lat !== exp_lat(dlys[i])) begin bad++; $display("FAIL timeout_lat dly=%0d: got %0d expected %0d", dlys[i], lat, exp_lat(dlys[i])); end
            rr_last = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] acks; int lat; logic [18:0] rsp, er; logic [32:0] addin; bit hold;
        er = exp_rsp(1'b1, 16'h4321, 16'h1234, 1'b1, 2);
        txn(1'b0, 1'b1, 16'h0, 16'h0, 16'h4321, 16'h1234, 1'b0, 1'b1, 2, 10, acks, lat, rsp, addin, hold);
        total++; if (rsp !== er) begin bad++; $display("FAIL bp_rsp: got %h expected %h", rsp, er); end
        total++; if (hold !== 1'b1) begin bad++; $display("FAIL bp_hold: got %b expected 1", hold); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_after: got %b expected 0", bus.rsp_valid); end
        rr_last = 1'b1;
    endtask

    task automatic test_back_to_back;
        int n;
        logic [18:0] er;
        ready_delay = 1;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 16'h0100; bus.req0_b = 16'h0001; bus.req0_sub = 1'b1;
        #1;
        n = 0;
        while (!bus.req0_ack && n < 30) begin @(negedge clk); #1; n++; end
        total++; if (bus.req0_ack !== 1'b1) begin bad++; $display("FAIL b2b_first_ack: got %b expected 1", bus.req0_ack); end
        rr_last = 1'b0;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
        total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_rsp: got %b expected 1", bus.rsp_valid); end
        bus.rsp_ready = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_a = 16'h8000; bus.req1_b = 16'h8000; bus.req1_sub = 1'b0;
        #1;
        total++; if (bus.req1_ack !== 1'b0) begin bad++; $display("FAIL b2b_ack_in_resp: got %b expected 0", bus.req1_ack); end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        total++; if ({bus.req1_ack, bus.rsp_valid} !== 2'b10) begin bad++; $display("FAIL b2b_next_ack: got %b expected 10", {bus.req1_ack, bus.rsp_valid}); end
        rr_last = 1'b1;
        @(negedge clk);
        bus.req1_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
        er = exp_rsp(1'b1, 16'h8000, 16'h8000, 1'b0, 1);
        total++; if ({bus.rsp_id, bus.rsp_err, bus.rsp_cout, bus.rsp_result} !== er) begin bad++; $display("FAIL b2b_second_rsp: got %h expected %h", {bus.rsp_id, bus.rsp_err, bus.rsp_cout, bus.rsp_result}, er); end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [1:0] acks; int lat, n, seen; logic [18:0] rsp, er; logic [32:0] addin; bit hold;
        ready_delay = -1;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 16'h00AA; bus.req0_b = 16'h0055; bus.req0_sub = 1'b0;
        #1;
        n = 0;
        while (!bus.req0_ack && n < 30) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus.add_en, bus.rsp_valid} !== 2'b00) begin bad++; $display("FAIL midreset_outputs: got %b expected 00", {bus.add_en, bus.rsp_valid}); end
        @(negedge clk);
        rst_n = 1'b1;
        rr_last = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.add_en) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midreset_no_rsp: got %0d active cycles expected 0", seen); end
        er = exp_rsp(1'b0, 16'h1111, 16'h2222, 1'b0, 2);
        txn(1'b1, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 1'b1, 2, 0, acks, lat, rsp, addin, hold);
        total++; if (acks !== 2'b01) begin bad++; $display("FAIL midreset_ptr: got %b expected 01", acks); end
        total++; if (rsp !== er) begin bad++; $display("FAIL midreset_next_rsp: got %h expected %h", rsp, er); end
        rr_last = 1'b0;
    endtask

    task automatic test_random;
        logic [1:0] acks, ea; int lat, el; logic [18:0] rsp, er; logic [32:0] addin, eai; bit hold;
        bit v0, v1, s0, s1, g; logic [15:0] a0, b0, a1, b1; int dly, stall, vv;
        for (int it = 0; it < 40; it++) begin
            vv = int'($urandom_range(1, 3));
            v0 = vv[0]; v1 = vv[1];
            a0 = 16'($urandom); b0 = 16'($urandom); s0 = 1'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom); s1 = 1'($urandom);
            dly   = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 6));
            stall = int'($urandom_range(0, 3));
            g   = exp_grant(v0, v1);
            ea  = g ? 2'b10 : 2'b01;
            er  = exp_rsp(g, g ? a1 : a0, g ? b1 : b0, g ? s1 : s0, dly);
            el  = exp_lat(dly);
            eai = {g ? s1 : s0, g ? a1 : a0, g ? b1 : b0};
            txn(v0, v1, a0, b0, a1, b1, s0, s1, dly, stall, acks, lat, rsp, addin, hold);
            total++; if (acks !== ea) begin bad++; $display("FAIL rand%0d_ack: got %b expected %b", it, acks, ea); end
            total++; if (rsp !== er) begin bad++; $display("FAIL rand%0d_rsp: got %h expected %h", it, rsp, er); end
            total++; if (lat !== el) begin bad++; $display("FAIL rand%0d_lat: got %0d expected %0d", it, lat, el); end
            total++; if (addin !== eai) begin bad++; $display("FAIL rand%0d_addin: got %h expected %h", it, addin, eai); end
            if (stall > 0) begin
                total++; if (hold !== 1'b1) begin bad++; $display("FAIL rand%0d_hold: got %b expected 1", it, hold); end
            end
            rr_last = g;
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.add_ready = 1'b0; bus.add_result = '0; bus.add_cout = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
